midi_voice_allocator: RTL and testbench

MIDI_VOICE_ALLOCATOR -- requirements
Module: midi_voice_allocator

---
 rtl/midi_voice_allocator_pkg.sv | 15 +
 rtl/voice_age_tracker.sv | 49 ++++
 rtl/midi_voice_allocator.sv | 187 ++++++++++++++++++
 tb/tb_midi_voice_allocator.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/midi_voice_allocator_pkg.sv
// Shared types and widths for the MIDI voice allocator and its age tracker.
package midi_voice_allocator_pkg;

    localparam int NUM_VOICES = 8;
    localparam int NOTE_W     = 6;
    localparam int VEL_W      = 8;
    localparam int VOICE_W    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/voice_age_tracker.sv
// Per-voice age ranks (0 newest .. 7 oldest), kept as a permutation of 0..7.
module voice_age_tracker
    import midi_voice_allocator_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_alloc,
    input  logic [VOICE_W-1:0] i_alloc_idx,
    output logic [VOICE_W-1:0] o_oldest_idx
);

    logic [VOICE_W-1:0] r_age      [NUM_VOICES];
    logic [VOICE_W-1:0] w_age_next [NUM_VOICES];
    logic [VOICE_W-1:0] w_old_age;

    assign w_old_age = r_age[i_alloc_idx];

    // Target becomes newest; only voices younger than it shift down one rank.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_age
            assign w_age_next[gi] = (i_alloc_idx == VOICE_W'(gi)) ? '0 :
                                    (r_age[gi] < w_old_age)       ? r_age[gi] + 1'b1 :
                                                                    r_age[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_age[i] <= VOICE_W'(i);
            end
        end else if (i_alloc) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                r_age[i] <= w_age_next[i];
            end
        end
    end

    always_comb begin
        o_oldest_idx = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (r_age[i] == VOICE_W'(NUM_VOICES - 1)) begin
                o_oldest_idx = VOICE_W'(i);
            end
        end
    end

endmodule

// File: rtl/midi_voice_allocator.sv
// Assigns note-on/note-off events to 8 voice slots with retrigger, free-slot and oldest-steal policy.
module midi_voice_allocator #(
    parameter int NUM_VOICES = 8
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       ev_valid,
    output logic                                       ev_ready,
    input  logic                                       ev_note_on,
    input  logic [midi_voice_allocator_pkg::NOTE_W-1:0] ev_note,
    input  logic [midi_voice_allocator_pkg::VEL_W-1:0]  ev_velocity,
    input  logic [NUM_VOICES-1:0]                      voice_done,
    output logic                                       update_voice,
    output logic [midi_voice_allocator_pkg::VOICE_W-1:0] voice_sel,
    output logic [midi_voice_allocator_pkg::NOTE_W-1:0] voice_note,
    output logic [midi_voice_allocator_pkg::VEL_W-1:0]  voice_velocity,
    output logic                                       voice_gate,
    output logic [NUM_VOICES-1:0]                      voice_busy,
    output logic                                       steal
);
    import midi_voice_allocator_pkg::*;

    state_t r_state, w_state_next;

    logic               r_ev_note_on;
    logic [NOTE_W-1:0]  r_ev_note;
    logic [VEL_W-1:0]   r_ev_vel;
    logic [VOICE_W-1:0] r_scan_idx;
    logic               r_match_found, r_free_found;
    logic [VOICE_W-1:0] r_match_idx, r_free_idx;

    logic [NUM_VOICES-1:0] r_busy, r_gate;
    logic [NOTE_W-1:0]     r_note [NUM_VOICES];
    logic [NUM_VOICES-1:0] w_busy_next, w_gate_next;
    logic [NOTE_W-1:0]     w_note_next [NUM_VOICES];

    logic               r_update, r_steal, r_gate_out;
    logic [VOICE_W-1:0] r_sel;
    logic [NOTE_W-1:0]  r_note_out;
    logic [VEL_W-1:0]   r_vel_out;

    logic               w_accept, w_scan_last, w_cur_match, w_cur_free;
    logic               w_match_found, w_free_found;
    logic [VOICE_W-1:0] w_match_idx, w_free_idx, w_oldest;
    logic               w_commit, w_tgt_gate, w_tgt_steal;
    logic [VOICE_W-1:0] w_tgt;

    always_comb begin
        w_state_next = r_state;
        ev_ready     = 1'b0;
        unique case (r_state)
            IDLE: begin
                ev_ready = 1'b1;
                if (ev_valid) w_state_next = SCAN;
            end
            SCAN:    if (w_scan_last) w_state_next = ISSUE;
            ISSUE:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    assign w_accept    = ev_valid && ev_ready;
    assign w_scan_last = (r_state == SCAN) && (r_scan_idx == VOICE_W'(NUM_VOICES - 1));
    assign w_cur_match = r_gate[r_scan_idx] && (r_note[r_scan_idx] == r_ev_note);
    assign w_cur_free  = !r_busy[r_scan_idx];

    // Fold the voice under examination in the final scan cycle into the decision.
    assign w_match_found = r_match_found || w_cur_match;
    assign w_match_idx   = r_match_found ? r_match_idx : r_scan_idx;
    assign w_free_found  = r_free_found || w_cur_free;
    assign w_free_idx    = r_free_found ? r_free_idx : r_scan_idx;

    always_comb begin
        w_commit    = 1'b0;
        w_tgt       = '0;
        w_tgt_gate  = 1'b0;
        w_tgt_steal = 1'b0;
        if (w_scan_last) begin
            if (r_ev_note_on) begin
                w_commit   = 1'b1;
                w_tgt_gate = 1'b1;
                if (w_match_found) begin
                    w_tgt = w_match_idx;
                end else if (w_free_found) begin
                    w_tgt = w_free_idx;
                end else begin
                    w_tgt       = w_oldest;
                    w_tgt_steal = 1'b1;
                end
            end else if (w_match_found) begin
                w_commit = 1'b1;
                w_tgt    = w_match_idx;
            end
        end
    end

    voice_age_tracker u_age (
        .clk          (clk),
        .reset        (reset),
        .i_alloc      (w_commit && r_ev_note_on),
        .i_alloc_idx  (w_tgt),
        .o_oldest_idx (w_oldest)
    );

    // An issue to a voice overrides a simultaneous release-done on that voice.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
            logic w_hit;
            assign w_hit = w_commit && (w_tgt == VOICE_W'(gi));
            assign w_busy_next[gi] = w_hit ? 1'b1 :
                                     (voice_done[gi] && !r_gate[gi]) ? 1'b0 : r_busy[gi];
            assign w_gate_next[gi] = w_hit ? w_tgt_gate : r_gate[gi];
            assign w_note_next[gi] = (w_hit && w_tgt_gate) ? r_ev_note : r_note[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy <= '0;
            r_gate <= '0;
            for (int i = 0; i < NUM_VOICES; i++) r_note[i] <= '0;
        end else begin
            r_busy <= w_busy_next;
            r_gate <= w_gate_next;
            for (int i = 0; i < NUM_VOICES; i++) r_note[i] <= w_note_next[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ev_note_on  <= 1'b0;
            r_ev_note     <= '0;
            r_ev_vel      <= '0;
            r_scan_idx    <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_update      <= 1'b0;
            r_steal       <= 1'b0;
            r_gate_out    <= 1'b0;
            r_sel         <= '0;
            r_note_out    <= '0;
            r_vel_out     <= '0;
        end else begin
            if (w_accept) begin
                r_ev_note_on  <= ev_note_on;
                r_ev_note     <= ev_note;
                r_ev_vel      <= ev_velocity;
                r_scan_idx    <= '0;
                r_match_found <= 1'b0;
                r_free_found  <= 1'b0;
            end else if (r_state == SCAN) begin
                r_scan_idx <= r_scan_idx + 1'b1;
                if (!r_match_found && w_cur_match) begin
                    r_match_found <= 1'b1;
                    r_match_idx   <= r_scan_idx;
                end
                if (!r_free_found && w_cur_free) begin
                    r_free_found <= 1'b1;
                    r_free_idx   <= r_scan_idx;
                end
            end
            r_update   <= w_commit;
            r_steal    <= w_commit && w_tgt_steal;
            r_gate_out <= w_commit && w_tgt_gate;
            r_sel      <= w_commit ? w_tgt : '0;
            r_note_out <= w_commit ? r_ev_note : '0;
            r_vel_out  <= (w_commit && r_ev_note_on) ? r_ev_vel : '0;
        end
    end

    assign update_voice   = r_update;
    assign steal          = r_steal;
    assign voice_gate     = r_gate_out;
    assign voice_sel      = r_sel;
    assign voice_note     = r_note_out;
    assign voice_velocity = r_vel_out;
    assign voice_busy     = r_busy;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Scoreboard bench: expected issues are queued on acceptance and compared when update_voice pulses.
module tb_midi_voice_allocator;

    logic       clk = 1'b0;
    logic       reset;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_note_on;
    logic [5:0] ev_note;
    logic [7:0] ev_velocity;
    logic [7:0] voice_done;
    logic       update_voice;
    logic [2:0] voice_sel;
    logic [5:0] voice_note;
    logic [7:0] voice_velocity;
    logic       voice_gate;
    logic [7:0] voice_busy;
    logic       steal;

    midi_voice_allocator #(.NUM_VOICES(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .ev_valid       (ev_valid),
        .ev_ready       (ev_ready),
        .ev_note_on     (ev_note_on),
        .ev_note        (ev_note),
        .ev_velocity    (ev_velocity),
        .voice_done     (voice_done),
        .update_voice   (update_voice),
        .voice_sel      (voice_sel),
        .voice_note     (voice_note),
        .voice_velocity (voice_velocity),
        .voice_gate     (voice_gate),
        .voice_busy     (voice_busy),
        .steal          (steal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic [5:0] note;
        logic [7:0] vel;
        logic       gate;
        logic       stl;
        logic [7:0] busy;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   n_pulse = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (update_voice) begin
            n_pulse++;
            $display("pulse cyc=%0d sel=%0d note=%0d vel=%0d gate=%0b steal=%0b busy=%02h",
                     cyc, voice_sel, voice_note, voice_velocity, voice_gate, steal, voice_busy);
            if (sb_q.size() == 0) begin
                check_value("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_value("latency", cyc, mon_e.cyc);
                check_value("sel",     voice_sel, mon_e.sel);
                check_value("note",    voice_note, mon_e.note);
                check_value("vel",     voice_velocity, mon_e.vel);
                check_value("gate",    voice_gate, mon_e.gate);
                check_value("steal",   steal, mon_e.stl);
                check_value("busy",    voice_busy, mon_e.busy);
            end
        end
    end

    task automatic check_reset_outputs(input string pfx);
        check_value({pfx, "_ready"},  ev_ready, 1);
        check_value({pfx, "_update"}, update_voice, 0);
        check_value({pfx, "_steal"},  steal, 0);
        check_value({pfx, "_busy"},   voice_busy, 0);
        check_value({pfx, "_sel"},    voice_sel, 0);
        check_value({pfx, "_note"},   voice_note, 0);
        check_value({pfx, "_vel"},    voice_velocity, 0);
        check_value({pfx, "_gate"},   voice_gate, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Present an event and hold it until accepted; acc is the cycle count at the accepting edge.
    task automatic accept(input logic on, input logic [5:0] note, input logic [7:0] vel, output int acc);
        acc = -1;
        @(negedge clk);
        ev_valid    = 1'b1;
        ev_note_on  = on;
        ev_note     = note;
        ev_velocity = vel;
        for (int k = 0; k < 50; k++) begin
            if (ev_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acc < 0) check_value("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 ev_valid = 1'b0;
    endtask

    task automatic send(input logic on, input logic [5:0] note, input logic [7:0] vel,
                        input logic pulse, input logic [2:0] sel, input logic stl, input logic [7:0] busy);
        int   acc;
        int   rdy;
        exp_t e;
        int   p0;
        p0 = n_pulse;
        e.cyc  = 0;
        e.sel  = sel;
        e.note = note;
        e.vel  = on ? vel : 8'd0;
        e.gate = on;
        e.stl  = stl;
        e.busy = busy;
        accept(on, note, vel, acc);
        e.cyc = acc + 9;
        if (pulse) sb_q.push_back(e);
        rdy = -1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (ev_ready) begin
                rdy = cyc;
                break;
            end
        end
        check_value("ready_latency", rdy - acc, 10);
        check_value("pulse_count", n_pulse - p0, pulse ? 1 : 0);
        check_value("sb_pending", sb_q.size(), 0);
        sb_q.delete();
    endtask

    task automatic pulse_done(input logic [7:0] v, input logic [7:0] busy_exp, input string tag);
        @(negedge clk);
        voice_done = v;
        @(negedge clk);
        voice_done = 8'h00;
        check_value(tag, voice_busy, busy_exp);
    endtask

    initial begin
        int acc;
        int p0;
        reset       = 1'b1;
        ev_valid    = 1'b0;
        ev_note_on  = 1'b0;
        ev_note     = '0;
        ev_velocity = '0;
        voice_done  = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;

        // Single note-on lands on voice 0
        send(1'b1, 6'd20, 8'd100, 1'b1, 3'd0, 1'b0, 8'h01);

        // Fill all voices, then steal oldest twice
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            send(1'b1, 6'(i), 8'd64, 1'b1, 3'(i - 1), 1'b0, 8'((1 << i) - 1));
        end
        send(1'b1, 6'd9, 8'd70, 1'b1, 3'd0, 1'b1, 8'hFF);
        send(1'b1, 6'd10, 8'd71, 1'b1, 3'd1, 1'b1, 8'hFF);

        // Note-off keeps busy until release is done
        do_reset();
        send(1'b1, 6'd30, 8'd90, 1'b1, 3'd0, 1'b0, 8'h01);
        send(1'b0, 6'd30, 8'd55, 1'b1, 3'd0, 1'b0, 8'h01);
        pulse_done(8'h01, 8'h00, "done_clears_busy");

        // Note-off with no holder is dropped
        do_reset();
        send(1'b0, 6'd45, 8'd0, 1'b0, 3'd0, 1'b0, 8'h00);

        // Retrigger reuses voice 0; done ignored while gated
        do_reset();
        send(1'b1, 6'd20, 8'd100, 1'b1, 3'd0, 1'b0, 8'h01);
        send(1'b1, 6'd20, 8'd110, 1'b1, 3'd0, 1'b0, 8'h01);
        pulse_done(8'h01, 8'h01, "done_ignored_gated");
        send(1'b1, 6'd21, 8'd50, 1'b1, 3'd1, 1'b0, 8'h03);

        // Reset during scan cycle 4 aborts the event
        do_reset();
        p0 = n_pulse;
        accept(1'b1, 6'd50, 8'd80, acc);
        repeat (5) @(negedge clk);
        check_value("scan_cycle", cyc - acc, 5);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midscan_rst");
        reset = 1'b0;
        repeat (15) @(negedge clk);
        check_value("abort_no_pulse", n_pulse - p0, 0);
        check_value("abort_ready", ev_ready, 1);

        check_value("sb_drain", sb_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
